// File: rtl/dmem_ctrl.sv
// Data-memory stage: word-addressed RAM behind a programmable wait-state FSM that stalls the core.
// Optional misaligned-access rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] addr,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        stall,
   output logic        err
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam bit ZERO_WAIT = (WAIT_STATES == 0);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [3:0]        r_cnt;
   logic [3:0]        w_nextCnt;
   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_req;
   logic [ADDR_W-1:0] w_idx;
   logic              w_misaligned;
   logic              w_done;
   logic              w_wrEn;
   logic              w_unused;

   assign w_req    = memRead | memWrite;
   assign w_idx    = addr[ADDR_W+1:2];
   assign w_unused = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_misaligned = (addr[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // Outputs are gated by reset so an in-flight access is dropped the moment reset asserts.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      stall       = 1'b0;
      err         = 1'b0;
      w_done      = 1'b0;
      if (reset) begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_misaligned) begin
                     err = 1'b1;
                  end else if (ZERO_WAIT) begin
                     w_done = 1'b1;
                  end else begin
                     stall       = 1'b1;
                     w_nextCnt   = CNT_INIT;
                     w_nextState = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!w_req) begin
                  w_nextState = S_IDLE;
                  w_nextCnt   = 4'd0;
               end else if (r_cnt == 4'd0) begin
                  w_done      = 1'b1;
                  w_nextState = S_IDLE;
               end else begin
                  stall     = 1'b1;
                  w_nextCnt = r_cnt - 4'd1;
               end
            end
            default: begin
               w_nextState = S_IDLE;
               w_nextCnt   = 4'd0;
            end
         endcase
      end
   end

   assign w_wrEn   = w_done & memWrite;
   assign readData = (w_done & memRead) ? r_mem[w_idx] : 32'd0;

   // RAM contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_mem[w_idx] <= writeData;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a WAIT_STATES=2 instance driven from a vector table
// plus hand sequences, and a WAIT_STATES=0 instance for the single-cycle path.
module tb_dmem_ctrl;

   logic        clk;
   logic        reset;

   logic        memRead2, memWrite2;
   logic [31:0] addr2, writeData2, readData2;
   logic        stall2, err2;

   logic        memRead0, memWrite0;
   logic [31:0] addr0, writeData0, readData0;
   logic        stall0, err0;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expStall;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs[$];

   dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dutWait (
      .clk(clk), .reset(reset),
      .memRead(memRead2), .memWrite(memWrite2),
      .addr(addr2), .writeData(writeData2),
      .readData(readData2), .stall(stall2), .err(err2)
   );

   dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dutZero (
      .clk(clk), .reset(reset),
      .memRead(memRead0), .memWrite(memWrite0),
      .addr(addr0), .writeData(writeData0),
      .readData(readData0), .stall(stall0), .err(err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      memRead2   = rd;
      memWrite2  = wr;
      addr2      = a;
      writeData2 = d;
      @(negedge clk);
   endtask

   task automatic addAccess(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] finalRd);
      vecs.push_back('{rd, wr, a, d, 1'b1, 32'd0});
      vecs.push_back('{rd, wr, a, d, 1'b1, 32'd0});
      vecs.push_back('{rd, wr, a, d, 1'b0, finalRd});
   endtask

   initial begin
      memRead2 = 0; memWrite2 = 0; addr2 = 0; writeData2 = 0;
      memRead0 = 0; memWrite0 = 0; addr0 = 0; writeData0 = 0;
      reset = 1'b0;

      addAccess(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'd0);
      vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0});
      addAccess(1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF);
      addAccess(1'b0, 1'b1, 32'h400, 32'h1,        32'd0);
      addAccess(1'b1, 1'b0, 32'h000, 32'h0,        32'h1);
      addAccess(1'b0, 1'b1, 32'h3FC, 32'hA5A50001, 32'd0);
      addAccess(1'b1, 1'b0, 32'h3FC, 32'h0,        32'hA5A50001);
      addAccess(1'b1, 1'b1, 32'h10,  32'h12345678, 32'hDEADBEEF);
      addAccess(1'b1, 1'b0, 32'h10,  32'h0,        32'h12345678);
      addAccess(1'b0, 1'b1, 32'h20,  32'hCAFE0020, 32'd0);

      #12;
      checkOutput("reset_stall", {31'd0, stall2}, 32'd0);
      checkOutput("reset_rd",    readData2,       32'd0);
      checkOutput("reset_err",   {31'd0, err2},   32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         checkOutput($sformatf("vec%0d_stall", i), {31'd0, stall2}, {31'd0, vecs[i].expStall});
         checkOutput($sformatf("vec%0d_rd", i),    readData2,       vecs[i].expRd);
         checkOutput($sformatf("vec%0d_err", i),   {31'd0, err2},   32'd0);
      end

      // Misaligned read of 0x22 hits word 0x20 unless the alignment check rejects it.
`ifdef DMEM_ALIGN_CHECK_EN
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h22, 32'h0);
         checkOutput("misal_err",   {31'd0, err2},   32'd1);
         checkOutput("misal_stall", {31'd0, stall2}, 32'd0);
         checkOutput("misal_rd",    readData2,       32'd0);
      end
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("misal_after_stall", {31'd0, stall2}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("misal_after_rd", readData2, 32'hCAFE0020);
`else
      applyStimulus(1'b1, 1'b0, 32'h22, 32'h0);
      checkOutput("misal_s1", {31'd0, stall2}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h22, 32'h0);
      checkOutput("misal_s2", {31'd0, stall2}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h22, 32'h0);
      checkOutput("misal_stall", {31'd0, stall2}, 32'd0);
      checkOutput("misal_rd",    readData2,       32'hCAFE0020);
      checkOutput("misal_err",   {31'd0, err2},   32'd0);
`endif

      // Abort after one stall cycle, then a fresh read must take the full wait again.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("abort_s1", {31'd0, stall2}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0);
      checkOutput("abort_stall", {31'd0, stall2}, 32'd0);
      checkOutput("abort_rd",    readData2,       32'd0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("abort_re_s1", {31'd0, stall2}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("abort_re_s2", {31'd0, stall2}, 32'd1);
      checkOutput("abort_re_rd0", readData2, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("abort_re_s3", {31'd0, stall2}, 32'd0);
      checkOutput("abort_re_rd", readData2, 32'hCAFE0020);

      // Reset in the middle of a write: outputs drop at once and the word is untouched.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h20, 32'hBAD0BAD0);
      checkOutput("rstmid_s1", {31'd0, stall2}, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h20, 32'hBAD0BAD0);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rstmid_stall", {31'd0, stall2}, 32'd0);
      checkOutput("rstmid_rd",    readData2,       32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      memWrite2 = 1'b0;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("rstmid_word_stall", {31'd0, stall2}, 32'd0);
      checkOutput("rstmid_word",       readData2,       32'hCAFE0020);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

      // Zero-wait instance: write then read the last word back-to-back.
      @(posedge clk); #1;
      memWrite0 = 1'b1; addr0 = 32'h3FC; writeData0 = 32'h0BADF00D;
      @(negedge clk);
      checkOutput("zw_wr_stall", {31'd0, stall0}, 32'd0);
      @(posedge clk); #1;
      memWrite0 = 1'b0; memRead0 = 1'b1;
      @(negedge clk);
      checkOutput("zw_rd_stall", {31'd0, stall0}, 32'd0);
      checkOutput("zw_rd",       readData0,       32'h0BADF00D);
      checkOutput("zw_err",      {31'd0, err0},   32'd0);
      @(posedge clk); #1;
      memRead0 = 1'b0;
      @(negedge clk);
      checkOutput("zw_idle_rd", readData0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
